unpacker_stream_ctrl: RTL and testbench
=======================================

// Module: unpacker_stream_ctrl
// PURPOSE
//  Sequencer for the word-decompression unpacker. Fetches 128-bit compressed chunks over a
//  valid/ready stream, builds the 196-bit refill window driven into the unpacker, and issues
//  the unpacker's decompress-enable and update strobes each cycle. Counts the two words
//  decoded per cycle and signals completion of one compressed block.
// PARAMETERS
//  WIDTH      128  compressed chunk width (bits)
//  WIDTH196   196  unpacker window width (bits)
//  LENGTH     6    codeword length field width, as produced by the unpacker
//  WORD       16   words per decompressed block (must be even)
//  MAX_CHUNKS 4    max compressed chunks per block
//  REFILL_TH  68   refill when post-consume bit count < REFILL_TH; 128+REFILL_TH <= WIDTH196
// PORTS
//  i_clk             in   1                    clock
//  i_reset           in   1                    reset, synchronous, active-high
//  i_start           in   1                    begin a block; sampled only in IDLE
//  i_num_chunks      in   $clog2(MAX_CHUNKS)+1 chunks in block, latched with i_start
//  i_chunk           in   WIDTH                compressed chunk payload
//  i_chunk_valid     in   1                    chunk stream valid
//  o_chunk_ready     out  1                    chunk accepted this cycle
//  i_first_length    in   LENGTH               unpacker first codeword length
//  i_second_length   in   LENGTH               unpacker second codeword length
//  i_remain_length   in   $clog2(WIDTH)+1      unpacker registered remaining-bit count
//  o_decompressor_en out  1                    unpacker consume enable
//  o_update          out  1                    unpacker load strobe for o_data
//  o_data            out  WIDTH196             refill window to unpacker
//  i_out_ready       in   1                    downstream can take a word pair
//  o_word_valid      out  1                    unpacker codes/indices valid this cycle
//  o_busy            out  1                    state != IDLE
//  o_done            out  1                    one-cycle pulse, block finished
//  o_error           out  1                    sticky; cleared by i_reset or next accepted i_start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; shadow window, word count, chunk count 0. Reset mid-block
//   aborts immediately, no o_done; partially accepted chunks are dropped.
//  consume = i_first_length + i_second_length (LENGTH+1 bits); never uses the unpacker's
//   enable-gated total, so no comb loop through o_decompressor_en.
//  post = i_remain_length - consume; need_refill = (post < REFILL_TH) && chunks_left != 0.
//  FSM: IDLE -> PRIME on i_start (i_num_chunks==0: set o_error, go DONE).
//   PRIME: o_chunk_ready=1; on i_chunk_valid: o_update=1, o_decompressor_en=0,
//    o_data={68'b0,i_chunk}, shadow<=same, chunks_left--, -> RUN. No valid: wait.
//   RUN, per cycle:
//    - !i_out_ready: en=0, update=0, hold all state.
//    - need_refill && !i_chunk_valid: en=0, hold (stall; ready stays 0).
//    - else: en=1, o_word_valid=1, words+=2; if need_refill: o_update=1, o_chunk_ready=1,
//      o_data = (shadow >> consume) | (i_chunk << post), chunks_left--;
//      else shadow <= shadow >> consume. Shadow always mirrors unpacker window.
//    - words reaching WORD in this cycle -> DONE.
//    - en cycle with consume > i_remain_length: set o_error (underflow), still go on counting.
//   DONE: o_done=1 one cycle; if chunks_left != 0 set o_error (unused chunks); -> IDLE.
//  i_start outside IDLE ignored. o_chunk_ready never asserted without i_chunk_valid needed.
//  Latency: first o_word_valid one cycle after PRIME chunk handshake; WORD/2 en cycles/block.
// CONFIGURATION
//  UNPACKER_CTRL_STATS_EN defined: adds outputs o_stall_cycles[15:0] (RUN cycles with en=0)
//   and o_block_cycles[15:0] (PRIME entry to DONE), cleared on accepted i_start, saturating.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Prime: i_start, num_chunks=1, chunk valid -> o_update=1, o_data[127:0]=chunk, en=0, RUN next.
//  Steady: lengths 6+6, remain 128, WORD=16 -> 8 en cycles, o_done at cycle 9, no refill.
//  Refill: remain=70, consume=12, chunks_left=1 -> post=58, o_update=1, o_data=(shadow>>12)|(chunk<<58).
//  Starve: need_refill with chunk_valid=0 for 3 cycles -> en=0, words frozen; resumes on valid.
//  Backpressure: i_out_ready=0 2 cycles mid-block -> no en, no word_valid, counts unchanged.
//  Errors/reset: num_chunks=0 -> o_error, o_done; i_reset in RUN -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/unpacker_stream_ctrl.sv
// Sequencer for the word-decompression unpacker: fetches compressed chunks, builds the refill
// window, strobes consume/update, counts decoded word pairs. Optional stats: UNPACKER_CTRL_STATS_EN.
module unpacker_stream_ctrl #(
  parameter int WIDTH      = 128,
  parameter int WIDTH196   = 196,
  parameter int LENGTH     = 6,
  parameter int WORD       = 16,
  parameter int MAX_CHUNKS = 4,
  parameter int REFILL_TH  = 68
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [$clog2(MAX_CHUNKS):0]   i_num_chunks,
  input  logic [WIDTH-1:0]              i_chunk,
  input  logic                          i_chunk_valid,
  output logic                          o_chunk_ready,
  input  logic [LENGTH-1:0]             i_first_length,
  input  logic [LENGTH-1:0]             i_second_length,
  input  logic [$clog2(WIDTH):0]        i_remain_length,
  output logic                          o_decompressor_en,
  output logic                          o_update,
  output logic [WIDTH196-1:0]           o_data,
  input  logic                          i_out_ready,
  output logic                          o_word_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error
`ifdef UNPACKER_CTRL_STATS_EN
  ,
  output logic [15:0]                   o_stall_cycles,
  output logic [15:0]                   o_block_cycles
`endif
);

  localparam int CNT_W  = $clog2(MAX_CHUNKS) + 1;
  localparam int REM_W  = $clog2(WIDTH) + 1;
  localparam int WCNT_W = $clog2(WORD) + 1;
  localparam logic [REM_W-1:0]  REFILL_TH_V = REM_W'(REFILL_TH);
  localparam logic [WCNT_W-1:0] WORD_V      = WCNT_W'(WORD);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [WIDTH196-1:0] r_shadow;
  logic [WCNT_W-1:0]   r_words;
  logic [CNT_W-1:0]    r_chunks_left;
  logic                r_error;

  logic [LENGTH:0]     w_consume;
  logic [REM_W-1:0]    w_consume_ext;
  logic [REM_W-1:0]    w_post;
  logic                w_underflow;
  logic                w_need_refill;
  logic [WIDTH196-1:0] w_chunk_ext;
  logic [WIDTH196-1:0] w_window_next;
  logic [WCNT_W-1:0]   w_words_inc;

  // Consume is built from the raw lengths, never from an enable-gated total, to avoid a
  // combinational loop through o_decompressor_en.
  assign w_consume     = {1'b0, i_first_length} + {1'b0, i_second_length};
  assign w_consume_ext = REM_W'(w_consume);
  assign w_post        = i_remain_length - w_consume_ext;
  assign w_underflow   = w_consume_ext > i_remain_length;
  assign w_need_refill = (w_post < REFILL_TH_V) && (r_chunks_left != '0);
  assign w_chunk_ext   = {{(WIDTH196-WIDTH){1'b0}}, i_chunk};
  assign w_words_inc   = r_words + WCNT_W'(2);

  always_comb begin
    o_chunk_ready     = 1'b0;
    o_update          = 1'b0;
    o_decompressor_en = 1'b0;
    o_word_valid      = 1'b0;
    w_window_next     = r_shadow;
    case (r_state)
      S_PRIME: begin
        o_chunk_ready = 1'b1;
        if (i_chunk_valid) begin
          o_update      = 1'b1;
          w_window_next = w_chunk_ext;
        end
      end
      S_RUN: begin
        if (i_out_ready && !(w_need_refill && !i_chunk_valid)) begin
          o_decompressor_en = 1'b1;
          o_word_valid      = 1'b1;
          if (w_need_refill) begin
            o_update      = 1'b1;
            o_chunk_ready = 1'b1;
            w_window_next = (r_shadow >> w_consume) | (w_chunk_ext << w_post);
          end else begin
            w_window_next = r_shadow >> w_consume;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_data  = o_update ? w_window_next : '0;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_error = r_error;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_shadow      <= '0;
      r_words       <= '0;
      r_chunks_left <= '0;
      r_error       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_words       <= '0;
            r_chunks_left <= i_num_chunks;
            if (i_num_chunks == '0) begin
              r_error <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_error <= 1'b0;
              r_state <= S_PRIME;
            end
          end
        end
        S_PRIME: begin
          if (i_chunk_valid) begin
            r_shadow      <= w_window_next;
            r_chunks_left <= r_chunks_left - CNT_W'(1);
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (o_decompressor_en) begin
            r_shadow <= w_window_next;
            r_words  <= w_words_inc;
            if (o_update)
              r_chunks_left <= r_chunks_left - CNT_W'(1);
            if (w_underflow)
              r_error <= 1'b1;
            if (w_words_inc >= WORD_V)
              r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Chunks announced but never fetched mean the block description was wrong.
          if (r_chunks_left != '0)
            r_error <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UNPACKER_CTRL_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_block_cycles;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= '0;
      r_block_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_start) begin
        r_stall_cycles <= '0;
        r_block_cycles <= '0;
      end
    end else begin
      if (r_block_cycles != 16'hFFFF)
        r_block_cycles <= r_block_cycles + 16'd1;
      if (r_state == S_RUN && !o_decompressor_en && r_stall_cycles != 16'hFFFF)
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_block_cycles = r_block_cycles;
`endif

endmodule

// File: tb/tb_unpacker_stream_ctrl.sv
// Directed self-checking bench for unpacker_stream_ctrl: prime, steady, refill, starve,
// backpressure, underflow, error and reset scenarios with hand-computed expectations.
module tb_unpacker_stream_ctrl;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [2:0]   i_num_chunks;
  logic [127:0] i_chunk;
  logic         i_chunk_valid;
  logic         o_chunk_ready;
  logic [5:0]   i_first_length;
  logic [5:0]   i_second_length;
  logic [7:0]   i_remain_length;
  logic         o_decompressor_en;
  logic         o_update;
  logic [195:0] o_data;
  logic         i_out_ready;
  logic         o_word_valid;
  logic         o_busy;
  logic         o_done;
  logic         o_error;
`ifdef UNPACKER_CTRL_STATS_EN
  logic [15:0]  o_stall_cycles;
  logic [15:0]  o_block_cycles;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] CA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] CB = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] CC = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;

  unpacker_stream_ctrl dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_num_chunks      (i_num_chunks),
    .i_chunk           (i_chunk),
    .i_chunk_valid     (i_chunk_valid),
    .o_chunk_ready     (o_chunk_ready),
    .i_first_length    (i_first_length),
    .i_second_length   (i_second_length),
    .i_remain_length   (i_remain_length),
    .o_decompressor_en (o_decompressor_en),
    .o_update          (o_update),
    .o_data            (o_data),
    .i_out_ready       (i_out_ready),
    .o_word_valid      (o_word_valid),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_error           (o_error)
`ifdef UNPACKER_CTRL_STATS_EN
    ,
    .o_stall_cycles    (o_stall_cycles),
    .o_block_cycles    (o_block_cycles)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_start         = 1'b0;
    i_num_chunks    = 3'd0;
    i_chunk         = '0;
    i_chunk_valid   = 1'b0;
    i_first_length  = 6'd6;
    i_second_length = 6'd6;
    i_remain_length = 8'd128;
    i_out_ready     = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic start_block(input logic [2:0] n);
    i_start      = 1'b1;
    i_num_chunks = n;
    tick();
    i_start      = 1'b0;
  endtask

  task automatic prime(input logic [127:0] c);
    i_chunk       = c;
    i_chunk_valid = 1'b1;
    tick();
    i_chunk_valid = 1'b0;
  endtask

  // Drives steady non-refill cycles until o_done; the cycle already in progress is k=1.
  task automatic run_block(input int max, output int en_cnt, output int done_k);
    en_cnt = 0;
    done_k = 0;
    for (int k = 1; k <= max; k++) begin
      #1;
      if (o_done) begin
        done_k = k;
        break;
      end
      if (o_decompressor_en) en_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset       = 1'b1;
    i_chunk_valid = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if ({o_busy, o_done, o_error, o_chunk_ready, o_update, o_decompressor_en, o_word_valid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {o_busy, o_done, o_error, o_chunk_ready, o_update, o_decompressor_en, o_word_valid});
    end
    total++;
    if (o_data !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", o_data);
    end
    i_reset       = 1'b0;
    i_chunk_valid = 1'b0;
    tick();
    $display("test_reset finished");
  endtask

  task automatic test_prime();
    logic [195:0] exp;
    exp           = {68'b0, CA};
    i_chunk       = CA;
    i_chunk_valid = 1'b1;
    i_start       = 1'b1;
    i_num_chunks  = 3'd1;
    #1;
    total++;
    if ({o_chunk_ready, o_update} !== 2'b00) begin
      bad++;
      $display("FAIL prime_idle_ready got=%b want=00", {o_chunk_ready, o_update});
    end
    tick();
    i_start = 1'b0;
    #1;
    total++;
    if ({o_chunk_ready, o_update, o_decompressor_en, o_word_valid, o_busy} !== 5'b11001) begin
      bad++;
      $display("FAIL prime_strobes got=%b want=11001",
               {o_chunk_ready, o_update, o_decompressor_en, o_word_valid, o_busy});
    end
    total++;
    if (o_data !== exp) begin
      bad++;
      $display("FAIL prime_data got=%h want=%h", o_data, exp);
    end
    tick();
    i_chunk_valid = 1'b0;
    #1;
    total++;
    if ({o_decompressor_en, o_word_valid, o_update, o_chunk_ready} !== 4'b1100) begin
      bad++;
      $display("FAIL prime_first_en got=%b want=1100",
               {o_decompressor_en, o_word_valid, o_update, o_chunk_ready});
    end
    $display("test_prime finished");
  endtask

  task automatic test_steady();
    int en_cnt, done_k;
    run_block(20, en_cnt, done_k);
    total++;
    if (en_cnt != 8) begin
      bad++;
      $display("FAIL steady_en_cycles got=%0d want=8", en_cnt);
    end
    total++;
    if (done_k != 9) begin
      bad++;
      $display("FAIL steady_done_cycle got=%0d want=9", done_k);
    end
    tick();
    #1;
    total++;
    if ({o_busy, o_done, o_error} !== 3'b000) begin
      bad++;
      $display("FAIL steady_after_done got=%b want=000", {o_busy, o_done, o_error});
    end
    $display("test_steady finished en=%0d done_at=%0d", en_cnt, done_k);
  endtask

  task automatic test_refill();
    logic [195:0] sh, exp;
    int en_cnt, done_k;
    apply_reset();
    start_block(3'd3);
    prime(CA);
    sh = {68'b0, CA};
    i_remain_length = 8'd70;
    i_chunk         = CB;
    i_chunk_valid   = 1'b1;
    #1;
    exp = (sh >> 12) | ({68'b0, CB} << 58);
    total++;
    if ({o_update, o_chunk_ready, o_decompressor_en} !== 3'b111) begin
      bad++;
      $display("FAIL refill1_strobes got=%b want=111", {o_update, o_chunk_ready, o_decompressor_en});
    end
    total++;
    if (o_data !== exp) begin
      bad++;
      $display("FAIL refill1_data got=%h want=%h", o_data, exp);
    end
    sh = exp;
    tick();
    i_remain_length = 8'd128;
    i_chunk_valid   = 1'b0;
    #1;
    total++;
    if ({o_update, o_chunk_ready, o_decompressor_en} !== 3'b001) begin
      bad++;
      $display("FAIL refill_plain_strobes got=%b want=001", {o_update, o_chunk_ready, o_decompressor_en});
    end
    sh = sh >> 12;
    tick();
    i_remain_length = 8'd70;
    i_chunk         = CC;
    i_chunk_valid   = 1'b1;
    #1;
    exp = (sh >> 12) | ({68'b0, CC} << 58);
    total++;
    if (o_data !== exp) begin
      bad++;
      $display("FAIL refill2_data got=%h want=%h", o_data, exp);
    end
    tick();
    i_chunk_valid   = 1'b0;
    i_remain_length = 8'd128;
    run_block(20, en_cnt, done_k);
    total++;
    if (en_cnt != 5 || done_k != 6) begin
      bad++;
      $display("FAIL refill_drain got=en%0d/done%0d want=en5/done6", en_cnt, done_k);
    end
    tick();
    #1;
    total++;
    if ({o_busy, o_error} !== 2'b00) begin
      bad++;
      $display("FAIL refill_end got=%b want=00", {o_busy, o_error});
    end
    $display("test_refill finished");
  endtask

  task automatic test_starve();
    logic [195:0] exp;
    int en_cnt, done_k;
    apply_reset();
    start_block(3'd2);
    prime(CA);
    i_remain_length = 8'd70;
    for (int s = 0; s < 3; s++) begin
      #1;
      total++;
      if ({o_decompressor_en, o_word_valid, o_chunk_ready, o_update} !== 4'b0000) begin
        bad++;
        $display("FAIL starve_cycle%0d got=%b want=0000", s,
                 {o_decompressor_en, o_word_valid, o_chunk_ready, o_update});
      end
      tick();
    end
    i_chunk       = CB;
    i_chunk_valid = 1'b1;
    #1;
    exp = ({68'b0, CA} >> 12) | ({68'b0, CB} << 58);
    total++;
    if ({o_decompressor_en, o_update, o_chunk_ready} !== 3'b111 || o_data !== exp) begin
      bad++;
      $display("FAIL starve_resume got=%b/%h want=111/%h",
               {o_decompressor_en, o_update, o_chunk_ready}, o_data, exp);
    end
    tick();
    i_chunk_valid   = 1'b0;
    i_remain_length = 8'd128;
    run_block(20, en_cnt, done_k);
    total++;
    if (en_cnt != 7 || done_k != 8) begin
      bad++;
      $display("FAIL starve_drain got=en%0d/done%0d want=en7/done8", en_cnt, done_k);
    end
    tick();
    $display("test_starve finished");
  endtask

  task automatic test_backpressure();
    int en_cnt, done_k, pre;
    apply_reset();
    start_block(3'd1);
    prime(CA);
    pre = 0;
    for (int s = 0; s < 3; s++) begin
      #1;
      if (o_decompressor_en) pre++;
      tick();
    end
    total++;
    if (pre != 3) begin
      bad++;
      $display("FAIL bp_pre_en got=%0d want=3", pre);
    end
    i_out_ready  = 1'b0;
    i_start      = 1'b1;
    i_num_chunks = 3'd0;
    for (int s = 0; s < 2; s++) begin
      #1;
      total++;
      if ({o_decompressor_en, o_word_valid, o_update, o_chunk_ready} !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b want=0000", s,
                 {o_decompressor_en, o_word_valid, o_update, o_chunk_ready});
      end
      tick();
    end
    i_start     = 1'b0;
    i_out_ready = 1'b1;
    run_block(20, en_cnt, done_k);
    total++;
    if (en_cnt != 5 || done_k != 6) begin
      bad++;
      $display("FAIL bp_drain got=en%0d/done%0d want=en5/done6", en_cnt, done_k);
    end
    tick();
    #1;
    total++;
    if ({o_busy, o_error} !== 2'b00) begin
      bad++;
      $display("FAIL bp_end got=%b want=00", {o_busy, o_error});
    end
    $display("test_backpressure finished");
  endtask

  task automatic test_underflow();
    int en_cnt, done_k;
    apply_reset();
    start_block(3'd1);
    prime(CA);
    i_remain_length = 8'd10;
    #1;
    total++;
    if ({o_decompressor_en, o_error} !== 2'b10) begin
      bad++;
      $display("FAIL underflow_cycle got=%b want=10", {o_decompressor_en, o_error});
    end
    tick();
    i_remain_length = 8'd128;
    #1;
    total++;
    if (o_error !== 1'b1) begin
      bad++;
      $display("FAIL underflow_flag got=%b want=1", o_error);
    end
    run_block(20, en_cnt, done_k);
    total++;
    if (en_cnt != 7 || done_k != 8) begin
      bad++;
      $display("FAIL underflow_drain got=en%0d/done%0d want=en7/done8", en_cnt, done_k);
    end
    tick();
    #1;
    total++;
    if ({o_busy, o_error} !== 2'b01) begin
      bad++;
      $display("FAIL underflow_sticky got=%b want=01", {o_busy, o_error});
    end
    $display("test_underflow finished");
  endtask

  task automatic test_errors();
    int en_cnt, done_k;
    apply_reset();
    start_block(3'd0);
    #1;
    total++;
    if ({o_done, o_error, o_busy} !== 3'b111) begin
      bad++;
      $display("FAIL zero_chunks_done got=%b want=111", {o_done, o_error, o_busy});
    end
    tick();
    #1;
    total++;
    if ({o_done, o_error, o_busy} !== 3'b010) begin
      bad++;
      $display("FAIL zero_chunks_idle got=%b want=010", {o_done, o_error, o_busy});
    end
    start_block(3'd2);
    #1;
    total++;
    if (o_error !== 1'b0) begin
      bad++;
      $display("FAIL error_clear_on_start got=%b want=0", o_error);
    end
    prime(CA);
    run_block(20, en_cnt, done_k);
    total++;
    if (en_cnt != 8 || done_k != 9 || o_error !== 1'b0) begin
      bad++;
      $display("FAIL unused_drain got=en%0d/done%0d/err%b want=en8/done9/err0", en_cnt, done_k, o_error);
    end
    tick();
    #1;
    total++;
    if (o_error !== 1'b1) begin
      bad++;
      $display("FAIL unused_chunks_error got=%b want=1", o_error);
    end
    start_block(3'd1);
    prime(CA);
    tick();
    i_chunk_valid = 1'b1;
    i_reset       = 1'b1;
    tick();
    #1;
    total++;
    if ({o_busy, o_done, o_error, o_chunk_ready, o_update, o_decompressor_en, o_word_valid} !== 7'b0
        || o_data !== '0) begin
      bad++;
      $display("FAIL reset_mid_run got=%b want=0000000",
               {o_busy, o_done, o_error, o_chunk_ready, o_update, o_decompressor_en, o_word_valid});
    end
    i_reset       = 1'b0;
    i_chunk_valid = 1'b0;
    tick();
    $display("test_errors finished");
  endtask

  initial begin
    test_reset();
    test_prime();
    test_steady();
    test_refill();
    test_starve();
    test_backpressure();
    test_underflow();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
